// File: rtl/trap_controller.sv
// Machine-mode trap controller: takes synchronous exceptions and mret at commit,
// owns mstatus/mtvec/mepc/mcause and the privilege mode, and issues a one-cycle
// redirect/flush to the front end.
module trap_controller #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic [3:0]  i_causeFromInst,
    input  logic        i_exceptionFromInst,
    input  logic        i_mret,
    input  logic        i_csrWe,
    input  logic [11:0] i_csrAddr,
    input  logic [31:0] i_csrWdata,
    output logic [31:0] o_csrRdata,
    output logic [1:0]  o_nowPrivMode,
    output logic        o_redirect,
    output logic [31:0] o_redirectPc,
    output logic        o_flush,
    output logic        o_busy
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    localparam logic [3:0] CAUSE_ECALL = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } state_e;

    state_e      state_q;
    logic [1:0]  priv_q;
    logic        mie_q;
    logic        mpie_q;
    logic [1:0]  mpp_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [31:0] mtvec_q;
    logic        redirect_q;
    logic        flush_q;
    logic        busy_q;
    logic [31:0] redirect_pc_q;

    logic        trap_take;
    logic        ret_take;
    logic        csr_wr;
    logic [3:0]  trap_cause_d;
    logic [1:0]  mpp_wr_d;
    logic [31:0] csr_rdata;

    // Low PC bits are never stored; instructions are word aligned.
    logic        unused_pc_lo;
    assign unused_pc_lo = ^i_pc[1:0];

    // Acceptance decode: only in IDLE, exception beats mret, CSR write loses to both.
    always_comb begin
        trap_take = 1'b0;
        ret_take  = 1'b0;
        csr_wr    = 1'b0;
        if (state_q == ST_IDLE) begin
            trap_take = i_valid & i_exceptionFromInst;
            ret_take  = i_valid & i_mret & ~i_exceptionFromInst;
            csr_wr    = i_csrWe & ~trap_take & ~ret_take;
        end
    end

    // ecall cause is specialised by the privilege it was raised from.
    always_comb begin
        trap_cause_d = i_causeFromInst;
        if (i_causeFromInst == CAUSE_ECALL) begin
            trap_cause_d = CAUSE_ECALL + 4'(priv_q);
        end
    end

    // MPP only holds the implemented modes; S/reserved encodings collapse to U.
    always_comb begin
        mpp_wr_d = PRIV_U;
        if (i_csrWdata[12:11] == PRIV_M) begin
            mpp_wr_d = PRIV_M;
        end
    end

    // Combinational CSR read of pre-edge state; unmapped addresses read zero.
    always_comb begin
        csr_rdata = 32'h0;
        case (i_csrAddr)
            CSR_MSTATUS: csr_rdata = {19'b0, mpp_q, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            CSR_MTVEC:   csr_rdata = mtvec_q;
            CSR_MEPC:    csr_rdata = mepc_q;
            CSR_MCAUSE:  csr_rdata = mcause_q;
            default:     csr_rdata = 32'h0;
        endcase
    end

    // FSM, architectural state and registered redirect outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            priv_q        <= PRIV_M;
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            mpp_q         <= PRIV_U;
            mepc_q        <= 32'h0;
            mcause_q      <= 32'h0;
            mtvec_q       <= MTVEC_RESET;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            busy_q        <= 1'b0;
            redirect_pc_q <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trap_take) begin
                        state_q       <= ST_TRAP;
                        mepc_q        <= {i_pc[31:2], 2'b00};
                        mcause_q      <= {28'b0, trap_cause_d};
                        mpie_q        <= mie_q;
                        mie_q         <= 1'b0;
                        mpp_q         <= priv_q;
                        priv_q        <= PRIV_M;
                        redirect_q    <= 1'b1;
                        flush_q       <= 1'b1;
                        busy_q        <= 1'b1;
                        redirect_pc_q <= {mtvec_q[31:2], 2'b00};
                    end else if (ret_take) begin
                        state_q       <= ST_RET;
                        priv_q        <= mpp_q;
                        mie_q         <= mpie_q;
                        mpie_q        <= 1'b1;
                        mpp_q         <= PRIV_U;
                        redirect_q    <= 1'b1;
                        flush_q       <= 1'b1;
                        busy_q        <= 1'b1;
                        redirect_pc_q <= mepc_q;
                    end else begin
                        redirect_q <= 1'b0;
                        flush_q    <= 1'b0;
                        busy_q     <= 1'b0;
                        if (csr_wr) begin
                            case (i_csrAddr)
                                CSR_MSTATUS: begin
                                    mie_q  <= i_csrWdata[3];
                                    mpie_q <= i_csrWdata[7];
                                    mpp_q  <= mpp_wr_d;
                                end
                                CSR_MTVEC:  mtvec_q  <= {i_csrWdata[31:2], 2'b00};
                                CSR_MEPC:   mepc_q   <= {i_csrWdata[31:2], 2'b00};
                                CSR_MCAUSE: mcause_q <= i_csrWdata;
                                default: ;
                            endcase
                        end
                    end
                end
                ST_TRAP, ST_RET: begin
                    state_q    <= ST_IDLE;
                    redirect_q <= 1'b0;
                    flush_q    <= 1'b0;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    redirect_q <= 1'b0;
                    flush_q    <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign o_csrRdata    = csr_rdata;
    assign o_nowPrivMode = priv_q;
    assign o_redirect    = redirect_q;
    assign o_flush       = flush_q;
    assign o_busy        = busy_q;
    assign o_redirectPc  = redirect_pc_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios followed by random
// traffic, all checked against an architectural model of the trap/CSR rules.
module tb_trap_controller;

    localparam logic [31:0] MTVEC_INIT = 32'h0000_0200;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  cause;
    logic        exc;
    logic        mret;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [1:0]  priv;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural model
    logic [1:0]  m_priv;
    logic        m_mie, m_mpie;
    logic [1:0]  m_mpp;
    logic [31:0] m_mepc, m_mcause, m_mtvec;
    logic        m_redirect;
    logic [31:0] m_redirect_pc;

    trap_controller #(.MTVEC_RESET(MTVEC_INIT)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_valid             (valid),
        .i_pc                (pc),
        .i_causeFromInst     (cause),
        .i_exceptionFromInst (exc),
        .i_mret              (mret),
        .i_csrWe             (csr_we),
        .i_csrAddr           (csr_addr),
        .i_csrWdata          (csr_wdata),
        .o_csrRdata          (csr_rdata),
        .o_nowPrivMode       (priv),
        .o_redirect          (redirect),
        .o_redirectPc        (redirect_pc),
        .o_flush             (flush),
        .o_busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [11:0] a);
        case (a)
            12'h300: return (32'(m_mpp) << 11) | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_edge();
        logic was_busy;
        was_busy = m_redirect;
        if (rst) begin
            m_priv = 2'b11; m_mie = 1'b0; m_mpie = 1'b0; m_mpp = 2'b00;
            m_mepc = 32'h0; m_mcause = 32'h0; m_mtvec = MTVEC_INIT;
            m_redirect = 1'b0;
        end else if (was_busy) begin
            m_redirect = 1'b0;
        end else if (valid && exc) begin
            m_redirect_pc = m_mtvec & ~32'h3;
            m_mepc   = pc & ~32'h3;
            m_mcause = (cause == 4'd8) ? 32'd8 + 32'(m_priv) : 32'(cause);
            m_mpie   = m_mie;
            m_mie    = 1'b0;
            m_mpp    = m_priv;
            m_priv   = 2'b11;
            m_redirect = 1'b1;
        end else if (valid && mret) begin
            m_redirect_pc = m_mepc;
            m_priv   = m_mpp;
            m_mie    = m_mpie;
            m_mpie   = 1'b1;
            m_mpp    = 2'b00;
            m_redirect = 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                12'h300: begin
                    m_mie  = csr_wdata[3];
                    m_mpie = csr_wdata[7];
                    m_mpp  = (csr_wdata[12:11] == 2'b11) ? 2'b11 : 2'b00;
                end
                12'h305: m_mtvec  = csr_wdata & ~32'h3;
                12'h341: m_mepc   = csr_wdata & ~32'h3;
                12'h342: m_mcause = csr_wdata;
                default: ;
            endcase
        end
    endtask

    // One clock: drive at negedge, check the combinational read, step edge, check state.
    task automatic cycle(input logic r, input logic v, input logic e, input logic [3:0] c,
                         input logic m, input logic [31:0] p, input logic we,
                         input logic [11:0] a, input logic [31:0] wd);
        @(negedge clk);
        rst = r; valid = v; exc = e; cause = c; mret = m; pc = p;
        csr_we = we; csr_addr = a; csr_wdata = wd;
        #1;
        check_eq("rdata", csr_rdata, model_read(a));
        @(posedge clk);
        model_edge();
        #1;
        check_eq("priv", 32'(priv), 32'(m_priv));
        check_eq("redirect", 32'(redirect), 32'(m_redirect));
        check_eq("flush", 32'(flush), 32'(m_redirect));
        check_eq("busy", 32'(busy), 32'(m_redirect));
        if (m_redirect) check_eq("redirect_pc", redirect_pc, m_redirect_pc);
    endtask

    task automatic idle(input logic [11:0] a);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, a, 32'h0);
    endtask

    // Read a CSR between edges and compare with a fixed expectation.
    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check_eq(tag, csr_rdata, exp);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; exc = 1'b0; cause = 4'd0; mret = 1'b0; pc = 32'h0;
        csr_we = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
        m_redirect = 1'b0; m_redirect_pc = 32'h0;
        m_priv = 2'b11; m_mie = 1'b0; m_mpie = 1'b0; m_mpp = 2'b00;
        m_mepc = 32'h0; m_mcause = 32'h0; m_mtvec = MTVEC_INIT;

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 12'h300, 32'h0);
        check_eq("rst_priv", 32'(priv), 32'h3);
        check_eq("rst_redirect", 32'(redirect), 32'h0);
        rd("rst_mtvec", 12'h305, MTVEC_INIT);
        rd("rst_mstatus", 12'h300, 32'h0);

        // Exception entry
        cycle(1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 32'h0000_0104, 1'b0, 12'h0, 32'h0);
        check_eq("trap_redirect", 32'(redirect), 32'h1);
        check_eq("trap_pc", redirect_pc, MTVEC_INIT);
        rd("trap_mepc", 12'h341, 32'h104);
        rd("trap_mcause", 12'h342, 32'h3);
        idle(12'h0);
        check_eq("trap_done", 32'(redirect), 32'h0);

        // mret back to U-mode
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 12'h300, 32'h0000_0080);
        cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 32'h0, 1'b0, 12'h0, 32'h0);
        check_eq("ret_pc", redirect_pc, 32'h104);
        idle(12'h0);
        check_eq("ret_priv", 32'(priv), 32'h0);
        rd("ret_mstatus", 12'h300, 32'h0000_0088);

        // ecall from U then from M
        cycle(1'b0, 1'b1, 1'b1, 4'd8, 1'b0, 32'h0000_0300, 1'b0, 12'h0, 32'h0);
        rd("ecall_u_cause", 12'h342, 32'd8);
        rd("ecall_u_mstatus", 12'h300, 32'h0000_0080);
        idle(12'h0);
        cycle(1'b0, 1'b1, 1'b1, 4'd8, 1'b0, 32'h0000_0400, 1'b0, 12'h0, 32'h0);
        rd("ecall_m_cause", 12'h342, 32'd11);
        rd("ecall_m_mstatus", 12'h300, 32'h0000_1800);
        idle(12'h0);

        // Exception + mret + CSR write together: trap wins, write dropped
        cycle(1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 32'h0000_0500, 1'b1, 12'h305, 32'hDEAD_0000);
        check_eq("prio_pc", redirect_pc, MTVEC_INIT);
        rd("prio_mtvec", 12'h305, MTVEC_INIT);
        idle(12'h0);

        // mtvec alignment and unmapped address
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 12'h305, 32'h8000_0003);
        rd("mtvec_align", 12'h305, 32'h8000_0000);
        cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1, 12'h7C0, 32'hFFFF_FFFF);
        rd("unmapped", 12'h7C0, 32'h0);

        // Reset during TRAP
        cycle(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 32'h0000_0600, 1'b0, 12'h0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0);
        check_eq("rst_trap_redirect", 32'(redirect), 32'h0);
        check_eq("rst_trap_priv", 32'(priv), 32'h3);
        check_eq("rst_trap_busy", 32'(busy), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] a;
            case ($urandom_range(0, 4))
                0: a = 12'h300;
                1: a = 12'h305;
                2: a = 12'h341;
                3: a = 12'h342;
                default: a = 12'($urandom);
            endcase
            cycle(($urandom_range(0, 63) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) == 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) == 0),
                  $urandom,
                  ($urandom_range(0, 1) == 0),
                  a,
                  $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
